// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Writeback request bundle between the two writeback requesters (port 0 = ALU,
//   port 1 = load/store unit) and the register-file write arbiter.
//   Parameters: AW register address width, DW data width.
//   Signals per port N:
//     reqN_valid  requester has a write pending
//     reqN_addr   destination register
//     reqN_data   write data
//     reqN_ready  grant from the arbiter; transfer when valid & ready
//   Modports: master (requester side), slave (arbiter side).
interface regfile_write_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of the register file (x0 hard-wired to zero)
//   between two writeback requesters. Arbitrates, registers the winning write
//   onto Write/D_address/D_data, and keeps a busy scoreboard so issue logic can
//   stall on registers that still have a pending producer.
//
//   Configuration macro: REGFILE_WR_FIXED_PRIO_EN
//     undefined (default): round-robin between the ports on a tie
//     defined            : fixed priority, port 0 always wins a tie
//
//   Ports:
//     clk        clock, all state updates on the rising edge
//     rst        asynchronous, active-low reset
//     req        writeback request bundle (slave side)
//     wr_hold    freeze; no grants while high
//     rsv_valid  issue logic reserves a destination register
//     rsv_addr   register being reserved
//     Write      register-file write enable
//     D_address  register-file write address
//     D_data     register-file write data
//     busy       scoreboard; bit i high means register i has a pending producer
module regfile_write_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave req,
  input  logic                  wr_hold,
  input  logic                  rsv_valid,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  Write,
  output logic [AW-1:0]         D_address,
  output logic [DW-1:0]         D_data,
  output logic [(1<<AW)-1:0]    busy
);

  logic          gnt0;
  logic          gnt1;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          win_commit;
  logic [(1<<AW)-1:0] busy_next;

`ifdef REGFILE_WR_FIXED_PRIO_EN
  // Port 0 always wins a tie; no grant history is needed.
  always_comb begin
    gnt0 = ~wr_hold & req.req0_valid;
    gnt1 = ~wr_hold & req.req1_valid & ~req.req0_valid;
  end
`else
  // last_grant: 0 = port 0 won the most recent transfer, 1 = port 1.
  logic last_grant;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!wr_hold) begin
      if (req.req0_valid && req.req1_valid) begin
        // Tie: the port that did not win last time gets the grant.
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req.req0_valid;
        gnt1 = req.req1_valid;
      end
    end
  end

  // Reset to 1 so port 0 wins the first tie. Only real transfers move it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end
`endif

  assign req.req0_ready = gnt0;
  assign req.req1_ready = gnt1;

  // Grants are mutually exclusive and imply valid, so a simple mux suffices.
  assign win_addr   = gnt1 ? req.req1_addr : req.req0_addr;
  assign win_data   = gnt1 ? req.req1_data : req.req0_data;
  // Writes to x0 are accepted but dropped here so x0 is never written.
  assign win_commit = (gnt0 | gnt1) && (win_addr != '0);

  // Registered write port. Address and data keep their last committed value
  // when no write is issued; reset discards any captured, uncommitted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Write     <= 1'b0;
      D_address <= '0;
      D_data    <= '0;
    end else begin
      Write <= win_commit;
      if (win_commit) begin
        D_address <= win_addr;
        D_data    <= win_data;
      end
    end
  end

  // Scoreboard: a committed write clears its bit at the same edge the register
  // file captures the data; a reservation in the same cycle is applied last so
  // it wins. Bit 0 is forced low because x0 never has a pending producer.
  always_comb begin
    busy_next = busy;
    if (Write) begin
      busy_next[D_address] = 1'b0;
    end
    if (rsv_valid) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the scoreboard is a reset-cleared flop vector, unlike a RAM
      // array, because issue logic must not see stale busy bits after reset.
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Scoreboard bench for regfile_write_arbiter. The driver applies one cycle of
//   stimulus at a time, predicts the grant from the arbitration rules, and
//   queues the expected register-file write and scoreboard value for the next
//   cycle. A monitor on the falling edge pops and compares whenever they fall due.
module tb_regfile_write_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGFILE_WR_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_hold = 1'b0;
  logic          rsv_valid = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          Write;
  logic [AW-1:0] D_address;
  logic [DW-1:0] D_data;
  logic [31:0]   busy;

  regfile_write_arbiter_if #(.AW(AW), .DW(DW)) rif ();

  regfile_write_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (rif),
    .wr_hold   (wr_hold),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .Write     (Write),
    .D_address (D_address),
    .D_data    (D_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [31:0] val;
  } bz_t;

  wr_t wq[$];
  bz_t bq[$];

  // Reference model state
  int          lg_m;       // port that won the last transfer
  logic [31:0] busy_m;     // register reservations not yet retired
  bit          cp_v;       // a write to cp_a commits in the current cycle
  logic [4:0]  cp_a;
  logic [4:0]  last_a;     // last committed address/data seen on the port
  logic [31:0] last_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic reset_models();
    wq.delete();
    bq.delete();
    lg_m   = 1;
    busy_m = '0;
    cp_v   = 1'b0;
    cp_a   = '0;
    last_a = '0;
    last_d = '0;
  endtask

  // One clock cycle of stimulus plus model update. Returns the predicted grant
  // (-1 none, 0 or 1).
  task automatic drive_cycle(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                             input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                             input bit hold, input bit rv, input logic [4:0] ra,
                             output int g);
    logic [31:0] nb;
    logic [4:0]  wa;
    logic [31:0] wd;
    @(posedge clk);
    #1;
    rif.req0_valid = v0; rif.req0_addr = a0; rif.req0_data = d0;
    rif.req1_valid = v1; rif.req1_addr = a1; rif.req1_data = d1;
    wr_hold = hold; rsv_valid = rv; rsv_addr = ra;

    g = -1;
    if (!hold) begin
      if (v0 && v1)  g = FIXED ? 0 : (lg_m == 0 ? 1 : 0);
      else if (v0)   g = 0;
      else if (v1)   g = 1;
    end

    #1;
    check("ready0", 32'(rif.req0_ready), 32'(g == 0));
    check("ready1", 32'(rif.req1_ready), 32'(g == 1));

    // Scoreboard value visible next cycle: retire this cycle's commit, then
    // apply the reservation (reservation wins on the same register).
    nb = busy_m;
    if (cp_v) nb[cp_a] = 1'b0;
    if (rv && ra != 0) nb[ra] = 1'b1;
    busy_m = nb;
    bq.push_back('{due: cyc + 1, val: nb});

    cp_v = 1'b0;
    if (g >= 0) begin
      wa = (g == 1) ? a1 : a0;
      wd = (g == 1) ? d1 : d0;
      if (wa != 0) begin
        wq.push_back('{due: cyc + 1, addr: wa, data: wd});
        cp_v = 1'b1;
        cp_a = wa;
      end
      lg_m = g;
    end
  endtask

  task automatic idle(output int g);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0, g);
  endtask

  // Monitor: compares the register-file port and the scoreboard every cycle.
  always @(negedge clk) begin
    wr_t e;
    bz_t b;
    while (wq.size() > 0 && wq[0].due < cyc) begin
      e = wq.pop_front();
      check("write_missed", 32'(e.due), 32'(cyc));
    end
    if (wq.size() > 0 && wq[0].due == cyc) begin
      e = wq.pop_front();
      check("write_en", 32'(Write), 32'd1);
      check("write_addr", 32'(D_address), 32'(e.addr));
      check("write_data", D_data, e.data);
      last_a = e.addr;
      last_d = e.data;
    end else begin
      check("write_idle", 32'(Write), 32'd0);
      check("hold_addr", 32'(D_address), 32'(last_a));
      check("hold_data", D_data, last_d);
    end
    while (bq.size() > 0 && bq[0].due < cyc) begin
      b = bq.pop_front();
      check("busy_missed", 32'(b.due), 32'(cyc));
    end
    if (bq.size() > 0 && bq[0].due == cyc) begin
      b = bq.pop_front();
      check("busy", busy, b.val);
    end
  end

  initial begin
    int g;
    bit p0v, p1v;
    logic [4:0]  p0a, p1a;
    logic [31:0] p0d, p1d;

    rif.req0_valid = 1'b0; rif.req0_addr = '0; rif.req0_data = '0;
    rif.req1_valid = 1'b0; rif.req1_addr = '0; rif.req1_data = '0;
    reset_models();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", 32'(Write), 32'd0);
    check("rst_addr", 32'(D_address), 32'd0);
    check("rst_data", D_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    #2 rst = 1'b1;

    // Single requester on port 1
    idle(g);
    drive_cycle(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, g);
    check("single_ready1", 32'(rif.req1_ready), 32'd1);
    idle(g);
    idle(g);

    // Tie: round-robin alternates, fixed priority always picks port 0
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 5'd1, $urandom(), 1, 5'd2, $urandom(), 0, 0, 5'd0, g);
      check("tie_ready0", 32'(rif.req0_ready), 32'((FIXED || (i % 2) == 0) ? 1 : 0));
    end
    idle(g);

    // x0 write is accepted but never committed
    drive_cycle(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 0, 0, 5'd0, g);
    check("x0_ready0", 32'(rif.req0_ready), 32'd1);
    idle(g);
    check("x0_write", 32'(Write), 32'd0);
    check("x0_busy0", 32'(busy[0]), 32'd0);

    // Scoreboard set / clear / set-wins
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 1, 5'd7, g);
    idle(g);
    check("rsv7_set", 32'(busy[7]), 32'd1);
    drive_cycle(1, 5'd7, 32'h0000_7777, 0, 5'd0, 32'd0, 0, 0, 5'd0, g);
    idle(g);
    check("rsv7_during_write", 32'(busy[7]), 32'd1);
    idle(g);
    check("rsv7_cleared", 32'(busy[7]), 32'd0);
    drive_cycle(1, 5'd7, 32'h0000_8888, 0, 5'd0, 32'd0, 0, 0, 5'd0, g);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 1, 5'd7, g);
    idle(g);
    check("rsv7_set_wins", 32'(busy[7]), 32'd1);

    // Hold: no grants while frozen, then the arbiter resumes
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 5'd3, 32'h3333_3333, 1, 5'd4, 32'h4444_4444, 1, 0, 5'd0, g);
      check("hold_no_ready", 32'({rif.req0_ready, rif.req1_ready}), 32'd0);
    end
    drive_cycle(1, 5'd3, 32'h3333_3333, 1, 5'd4, 32'h4444_4444, 0, 0, 5'd0, g);
    check("hold_release_ready1", 32'(rif.req1_ready), 32'(FIXED ? 0 : 1));
    idle(g);

    // Reset while a captured write is pending
    drive_cycle(1, 5'd9, 32'h9999_9999, 0, 5'd0, 32'd0, 0, 0, 5'd0, g);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rif.req0_valid = 1'b0; rif.req1_valid = 1'b0;
    reset_models();
    #1;
    check("midrst_write", 32'(Write), 32'd0);
    check("midrst_addr", 32'(D_address), 32'd0);
    check("midrst_data", D_data, 32'd0);
    check("midrst_busy", busy, 32'd0);
    #2 rst = 1'b1;
    drive_cycle(1, 5'd10, 32'hA0A0_A0A0, 1, 5'd11, 32'hB1B1_B1B1, 0, 0, 5'd0, g);
    check("midrst_first_tie", 32'(rif.req0_ready), 32'd1);
    idle(g);

    // Randomized traffic; a requester holds its request until granted
    p0v = 0; p1v = 0;
    p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0v && ($urandom_range(0, 2) != 0)) begin
        p0v = 1; p0a = 5'($urandom_range(0, 31)); p0d = $urandom();
      end
      if (!p1v && ($urandom_range(0, 2) != 0)) begin
        p1v = 1; p1a = 5'($urandom_range(0, 31)); p1d = $urandom();
      end
      drive_cycle(p0v, p0a, p0d, p1v, p1a, p1d,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 31)), g);
      if (g == 0) p0v = 0;
      if (g == 1) p1v = 0;
    end
    repeat (3) idle(g);
    @(negedge clk);
    #1;
    check("write_queue_drained", 32'(wq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
